reg_writeback_queue: RTL
========================

Name: reg_writeback_queue

Overview:
- Writeback stage directly upstream of the 16x16 register file.
- Collects register-write requests from the ALU result path and the memory-load path in a small in-order FIFO.
- Drains one entry per cycle onto the register file's Write / WriteAddr / DataIn inputs.
- Reports pending-write hazards so decode can stall reads of registers whose write has not yet landed.

Parameters:
- DATA_W, 16, data width; matches register file DataIn.
- ADDR_W, 4, register address width; 16 registers.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- AluValid  in  1  ALU write request.
- AluAddr  in  ADDR_W  ALU destination register.
- AluData  in  DATA_W  ALU result.
- AluReady  out  1  ALU request accepted this cycle.
- MemValid  in  1  load write request.
- MemAddr  in  ADDR_W  load destination register.
- MemData  in  DATA_W  load data.
- MemReady  out  1  load request accepted this cycle.
- Hold  in  1  register file write port unavailable; suppresses drain.
- Write  out  1  register file write enable.
- WriteAddr  out  ADDR_W  register file write address.
- DataIn  out  DATA_W  register file write data.
- ChkAddrA  in  ADDR_W  decode read address A to check.
- ChkAddrB  in  ADDR_W  decode read address B to check.
- HazardA  out  1  a queued entry targets ChkAddrA.
- HazardB  out  1  a queued entry targets ChkAddrB.
- Count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset state: RST_N low clears head/tail pointers and Count to 0; Write=0, WriteAddr=0, DataIn=0, HazardA/B=0, AluReady=MemReady=1 (queue empty).
- Reset mid-operation: all queued entries are discarded; nothing is written to the register file.
- Enqueue is at most one entry per cycle.
  - MemReady = (Count != DEPTH).
  - AluReady = (Count != DEPTH) && !MemValid. Memory has priority because the load is the older instruction.
  - A request is accepted at the rising edge when its Valid and Ready are both high. The {addr,data} pair is written at tail and tail advances, wrapping modulo DEPTH.
- Drain:
  - Write = (Count != 0) && !Hold. WriteAddr/DataIn = head entry when Count != 0, else 0.
  - These outputs are combinational from registered FIFO state; no path from Valid inputs reaches them.
  - When Write=1, the register file captures at the rising edge, and head advances (wrapping) at that same edge.
- Latency: a request accepted at edge N appears on Write/WriteAddr/DataIn during cycle N..N+1 and is committed at edge N+1 if Hold=0. There is no same-cycle bypass from input to output.
- Simultaneous enqueue and drain: Count unchanged.
- Full: Ready is low even when a drain occurs that cycle; there is no pass-through when full.
- Empty: Write=0 regardless of Hold.
- Hold=1: head and outputs are frozen and Write=0. Enqueue continues until full.
- Duplicate addresses in the queue are legal. Entries commit in order, so the last-written value wins in the register file.
- HazardA: combinational OR over valid entries of (entry.addr == ChkAddrA). HazardB is the same for ChkAddrB.
  - Only entries present at the start of the cycle count; the entry being enqueued this cycle does not.
  - The entry being drained this cycle still counts.
- Count: registered; increments on accept-only, decrements on drain-only; never exceeds DEPTH.

Decomposition:
- Shared package (processor-wide): DATA_W=16, ADDR_W=4, and a wb_entry_t struct {addr, data}.
- One natural sub-module: wb_fifo (generic DEPTH x entry storage with push/pop/pointers/Count).
- Arbitration, hazard compare and output muxing stay in reg_writeback_queue.

Test Plan:
- Single write: reset; AluValid=1, AluAddr=3, AluData=0x00AA for one cycle -> next cycle Write=1, WriteAddr=3, DataIn=0x00AA, Count=1; the following cycle Write=0, Count=0, and a register file read of address 3 returns 0x00AA.
- Priority: MemValid=1 (5, 0x1111) and AluValid=1 (6, 0x2222) in the same cycle -> MemReady=1, AluReady=0. Holding ALU valid one more cycle -> commits in order: addr 5 = 0x1111 then addr 6 = 0x2222.
- Full and hold: Hold=1; enqueue ALU (1,0x0001)..(4,0x0004) -> Count=4, AluReady=MemReady=0, Write=0. A fifth request is not accepted. Release Hold -> four consecutive writes of 0x0001..0x0004 to addresses 1..4.
- Wrap-around: with Hold=0, stream 10 ALU requests to addresses 0..9 with data 1..10 -> each is written exactly once, in order; Count never exceeds 1; pointers wrap cleanly past DEPTH.
- Hazard: Hold=1; enqueue (7, 0x0BAD); ChkAddrA=7, ChkAddrB=8 -> HazardA=1, HazardB=0. Release Hold -> HazardA drops the cycle after the write commits.
- Reset mid-operation: Hold=1, three entries queued; pulse RST_N low asynchronously between edges -> Count=0, Write=0, HazardA/B=0 immediately. After release, no register file writes occur.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// rtl/reg_writeback_queue_pkg.sv - processor-wide register-writeback types and widths
//
// Purpose: register-file geometry shared by the writeback stage, decode and the
//          register file itself, plus the queued write entry type.
// Ports:   none (package).

package reg_writeback_queue_pkg;

   localparam int DATA_W   = 16;  // register file DataIn width
   localparam int ADDR_W   = 4;   // 16 architectural registers
   localparam int WB_DEPTH = 4;   // default writeback queue depth

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - request, register-file and hazard signals of the writeback queue
//
// Purpose: bundles the ALU/load request handshakes, the register file write port
//          and the decode hazard check into one interface.
// Ports:   slave modport is the queue side; master modport is the surrounding
//          pipeline (ALU, load unit, register file, decode).

interface reg_writeback_queue_if
   import reg_writeback_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              AluValid;
   logic [ADDR_W-1:0] AluAddr;
   logic [DATA_W-1:0] AluData;
   logic              AluReady;

   logic              MemValid;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemData;
   logic              MemReady;

   logic              Hold;
   logic              Write;
   logic [ADDR_W-1:0] WriteAddr;
   logic [DATA_W-1:0] DataIn;

   logic [ADDR_W-1:0] ChkAddrA;
   logic [ADDR_W-1:0] ChkAddrB;
   logic              HazardA;
   logic              HazardB;

   logic [CNT_W-1:0]  Count;

   modport slave (
      input  AluValid, AluAddr, AluData,
      output AluReady,
      input  MemValid, MemAddr, MemData,
      output MemReady,
      input  Hold,
      output Write, WriteAddr, DataIn,
      input  ChkAddrA, ChkAddrB,
      output HazardA, HazardB,
      output Count
   );

   modport master (
      output AluValid, AluAddr, AluData,
      input  AluReady,
      output MemValid, MemAddr, MemData,
      input  MemReady,
      output Hold,
      input  Write, WriteAddr, DataIn,
      output ChkAddrA, ChkAddrB,
      input  HazardA, HazardB,
      input  Count
   );

endinterface

// File: rtl/reg_writeback_queue_wb_fifo.sv
// rtl/reg_writeback_queue_wb_fifo.sv - in-order DEPTH-entry storage for pending register writes
//
// Purpose: circular buffer of wb_entry_t with head/tail pointers and occupancy.
//          The caller guarantees push only when not full and pop only when not empty.
// Ports:   clk, rst_n      clock, asynchronous active-low reset
//          push/push_entry  write push_entry at tail
//          pop              retire the head entry
//          head_entry       entry at head (meaningful when count != 0)
//          entries          raw storage, for hazard comparison
//          valid_vec        per-slot occupancy flag
//          count            occupied entries

module wb_fifo
   import reg_writeback_queue_pkg::*;
#(
   parameter  int DEPTH = WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   output wb_entry_t        head_entry,
   output wb_entry_t        entries [DEPTH],
   output logic [DEPTH-1:0] valid_vec,
   output logic [CNT_W-1:0] count
);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] rel;

   // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (push) begin
         mem_d[tail_q] = push_entry;
         tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   // A slot is occupied when its distance from head (mod DEPTH) is below count.
   always_comb begin
      valid_vec = '0;
      rel       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rel          = PTR_W'(i) - head_q;
         valid_vec[i] = CNT_W'(rel) < count_q;
      end
   end

   assign head_entry = mem_q[head_q];
   assign entries    = mem_q;
   assign count      = count_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - writeback queue between ALU/load results and the register file
//
// Purpose: accepts at most one register write per cycle (load before ALU), holds
//          them in order, drains one per cycle to the register file unless held,
//          and flags decode reads whose register still has a queued write.
// Ports:   CLK     system clock
//          RST_N   asynchronous active-low reset; discards all queued writes
//          bus     reg_writeback_queue_if slave: Alu*/Mem* requests, Hold,
//                  Write/WriteAddr/DataIn, ChkAddrA/B, HazardA/B, Count

module reg_writeback_queue
   import reg_writeback_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   reg_writeback_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic             push;
   logic             pop;
   logic             not_full;
   logic             not_empty;
   wb_entry_t        push_entry;
   wb_entry_t        head_entry;
   wb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid_vec;
   logic [CNT_W-1:0] count;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (CLK),
      .rst_n      (RST_N),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .entries    (entries),
      .valid_vec  (valid_vec),
      .count      (count)
   );

   assign not_full  = (count != FULL_CNT);
   assign not_empty = (count != '0);

   // The load is the older instruction, so it takes the single enqueue slot.
   // Readiness depends only on registered occupancy: no pass-through when full.
   assign bus.MemReady = not_full;
   assign bus.AluReady = not_full && !bus.MemValid;

   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (bus.MemValid && not_full) begin
         push       = 1'b1;
         push_entry = '{addr: bus.MemAddr, data: bus.MemData};
      end else if (bus.AluValid && not_full) begin
         push       = 1'b1;
         push_entry = '{addr: bus.AluAddr, data: bus.AluData};
      end
   end

   // Drain outputs come only from registered queue state; there is no bypass
   // from the request inputs.
   assign pop           = not_empty && !bus.Hold;
   assign bus.Write     = pop;
   assign bus.WriteAddr = not_empty ? head_entry.addr : '0;
   assign bus.DataIn    = not_empty ? head_entry.data : '0;

   // The entry being drained still counts; one being enqueued does not yet.
   always_comb begin
      bus.HazardA = 1'b0;
      bus.HazardB = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_vec[i] && (entries[i].addr == bus.ChkAddrA)) begin
            bus.HazardA = 1'b1;
         end
         if (valid_vec[i] && (entries[i].addr == bus.ChkAddrB)) begin
            bus.HazardB = 1'b1;
         end
      end
   end

   assign bus.Count = count;

endmodule
